// File: rtl/fifo_seq_checker.sv
// fifo_seq_checker
//   Read-side consumer for the async_fifo_top loopback path. It runs in the
//   wclk domain on the return FIFO read port, with rclk tied to wclk. It drains
//   the FIFO under flow control and checks that the returned words form an
//   incrementing sequence. Each word is classified as a match, a gap (words
//   dropped upstream) or a hard error.
//
// Ports
//   wclk           clock
//   wrst_n         synchronous active-low reset
//   enable         start/continue checking; low pauses reading
//   rempty         FIFO empty flag
//   rdata[DW]      FIFO read data
//   rvalid         rdata valid, one cycle after an accepted read
//   rinc           read request (combinational)
//   match_cnt[CW]  words equal to the expected value (saturating)
//   gap_cnt[CW]    dropped words inferred from forward jumps (saturating)
//   err_cnt[CW]    words outside the match/gap window (saturating)
//   err_flag       sticky, set on the first hard error
//   first_err_data rdata of the first hard error
//   first_err_exp  expected value at the first hard error
//   done           sticky, high once NUM_WORDS words have been checked
module fifo_seq_checker #(
  parameter int DW        = 16,
  parameter int MAX_GAP   = 64,
  parameter int NUM_WORDS = 1024,
  parameter int PACE      = 0,
  parameter int CW        = 16
) (
  input  logic          wclk,
  input  logic          wrst_n,
  input  logic          enable,
  input  logic          rempty,
  input  logic [DW-1:0] rdata,
  input  logic          rvalid,
  output logic          rinc,
  output logic [CW-1:0] match_cnt,
  output logic [CW-1:0] gap_cnt,
  output logic [CW-1:0] err_cnt,
  output logic          err_flag,
  output logic [DW-1:0] first_err_data,
  output logic [DW-1:0] first_err_exp,
  output logic          done
);

  localparam int PW = (PACE > 0) ? $clog2(PACE + 1) : 1;
  // Wide enough that gap_cnt + diff cannot overflow before the saturation test.
  localparam int SW = ((CW > DW) ? CW : DW) + 1;

  typedef enum logic [1:0] {IDLE, SYNC, RUN, DONE} state_t;

  state_t        state;
  logic [DW-1:0] expected;
  logic [PW-1:0] pace_cnt;
  logic [31:0]   word_cnt;

  logic [DW-1:0] diff;
  logic          in_gap;
  logic [SW-1:0] gap_sum;
  logic          last_word;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  always_comb begin
    rinc      = ((state == SYNC) || (state == RUN)) && enable && !rempty &&
                (pace_cnt == '0);
    diff      = rdata - expected;
    in_gap    = (diff != '0) && (SW'(diff) <= SW'(MAX_GAP));
    gap_sum   = SW'(gap_cnt) + SW'(diff);
    // The word being processed this cycle is the NUM_WORDS-th one.
    last_word = (NUM_WORDS != 0) && ((word_cnt + 32'd1) == 32'(NUM_WORDS));
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state          <= IDLE;
      expected       <= '0;
      pace_cnt       <= '0;
      word_cnt       <= '0;
      match_cnt      <= '0;
      gap_cnt        <= '0;
      err_cnt        <= '0;
      err_flag       <= 1'b0;
      first_err_data <= '0;
      first_err_exp  <= '0;
      done           <= 1'b0;
    end else begin
      // rinc already excludes rempty, so it marks exactly the accepted reads.
      if (rinc) begin
        pace_cnt <= PW'(PACE);
      end else if (pace_cnt != '0) begin
        pace_cnt <= pace_cnt - PW'(1);
      end

      case (state)
        IDLE: begin
          if (enable) state <= SYNC;
        end

        SYNC: begin
          if (rvalid) begin
            match_cnt <= sat_inc(match_cnt);
            expected  <= rdata + DW'(1);
            word_cnt  <= word_cnt + 32'd1;
            if (last_word) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (rvalid) begin
            if (diff == '0) begin
              match_cnt <= sat_inc(match_cnt);
            end else if (in_gap) begin
              gap_cnt <= (gap_sum > SW'({CW{1'b1}})) ? '1 : gap_sum[CW-1:0];
            end else begin
              err_cnt <= sat_inc(err_cnt);
              if (!err_flag) begin
                err_flag       <= 1'b1;
                first_err_data <= rdata;
                first_err_exp  <= expected;
              end
            end
            // Resync on every word so one bad word costs a single error.
            expected <= rdata + DW'(1);
            word_cnt <= word_cnt + 32'd1;
            if (last_word) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        DONE: begin
          done <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_seq_checker.sv
// Testbench for fifo_seq_checker. Instance A (defaults) is fed from a word
// queue acting as the return FIFO; instance B (PACE=2, NUM_WORDS=8) is fed an
// endless incrementing source with a bench-driven empty flag.
module tb_fifo_seq_checker;

  logic        wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Instance A
  logic        wrst_n, enable_a, rempty_a, rvalid_a, rinc_a;
  logic [15:0] rdata_a, match_a, gap_a, err_a, fed_a, fee_a;
  logic        flag_a, done_a;
  // Instance B
  logic        rst_b, en_b, rempty_b, rvalid_b, rinc_b;
  logic [15:0] rdata_b, match_b, gap_b, err_b, fed_b, fee_b;
  logic        flag_b, done_b;

  fifo_seq_checker #(.DW(16), .MAX_GAP(64), .NUM_WORDS(1024), .PACE(0), .CW(16)) u_dut_a (
    .wclk(wclk), .wrst_n(wrst_n), .enable(enable_a), .rempty(rempty_a),
    .rdata(rdata_a), .rvalid(rvalid_a), .rinc(rinc_a), .match_cnt(match_a),
    .gap_cnt(gap_a), .err_cnt(err_a), .err_flag(flag_a),
    .first_err_data(fed_a), .first_err_exp(fee_a), .done(done_a));

  fifo_seq_checker #(.DW(16), .MAX_GAP(64), .NUM_WORDS(8), .PACE(2), .CW(16)) u_dut_b (
    .wclk(wclk), .wrst_n(rst_b), .enable(en_b), .rempty(rempty_b),
    .rdata(rdata_b), .rvalid(rvalid_b), .rinc(rinc_b), .match_cnt(match_b),
    .gap_cnt(gap_b), .err_cnt(err_b), .err_flag(flag_b),
    .first_err_data(fed_b), .first_err_exp(fee_b), .done(done_b));

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          rd_a[$];
  int          rd_b[$];
  logic [15:0] qa[$];
  logic [15:0] nxt_b;
  logic        rinc_a_s, rinc_b_s, rempty_b_s;
  logic        acc_a, acc_b;
  logic [15:0] pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample rinc mid-cycle, then play the FIFO response just
  // after the rising edge.
  task automatic tick();
    @(negedge wclk);
    rinc_a_s   = rinc_a;
    rinc_b_s   = rinc_b;
    rempty_b_s = rempty_b;
    acc_a      = rinc_a && !rempty_a;
    acc_b      = rinc_b && !rempty_b;
    if (acc_a) rd_a.push_back(cyc);
    if (acc_b) rd_b.push_back(cyc);
    @(posedge wclk);
    #1;
    rvalid_a = acc_a;
    if (acc_a) rdata_a = qa.pop_front();
    rempty_a = (qa.size() == 0);
    rvalid_b = acc_b;
    if (acc_b) begin
      rdata_b = nxt_b;
      nxt_b   = nxt_b + 16'd1;
    end
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_a(input logic [15:0] w);
    qa.push_back(w);
    rempty_a = 1'b0;
  endtask

  task automatic reset_a();
    wrst_n = 1'b0;
    qa.delete();
    rempty_a = 1'b1;
    ticks(2);
    wrst_n = 1'b1;
  endtask

  initial begin
    wrst_n = 1'b0; enable_a = 1'b0; rempty_a = 1'b1; rvalid_a = 1'b0; rdata_a = '0;
    rst_b  = 1'b0; en_b     = 1'b0; rempty_b = 1'b1; rvalid_b = 1'b0; rdata_b = '0;
    nxt_b  = 16'd0;

    // Reset state
    ticks(3);
    chk("rst_match", match_a, 0);
    chk("rst_gap",   gap_a,   0);
    chk("rst_err",   err_a,   0);
    chk("rst_flag",  flag_a,  0);
    chk("rst_fed",   fed_a,   0);
    chk("rst_fee",   fee_a,   0);
    chk("rst_done",  done_a,  0);
    chk("rst_rinc",  rinc_a_s, 0);

    // 0..9 back to back
    wrst_n = 1'b1;
    for (int i = 0; i < 10; i++) push_a(16'(i));
    enable_a = 1'b1;
    rd_a.delete();
    ticks(15);
    chk("seq_reads",  rd_a.size(), 10);
    chk("seq_b2b",    rd_a[9] - rd_a[0], 9);
    chk("seq_match",  match_a, 10);
    chk("seq_gap",    gap_a,   0);
    chk("seq_err",    err_a,   0);
    chk("seq_flag",   flag_a,  0);

    // 0,1,2,7,8 then 9
    reset_a();
    push_a(16'd0); push_a(16'd1); push_a(16'd2); push_a(16'd7); push_a(16'd8);
    ticks(10);
    chk("gap_match", match_a, 4);
    chk("gap_gap",   gap_a,   4);
    chk("gap_err",   err_a,   0);
    push_a(16'd9);
    ticks(4);
    chk("gap_next9", match_a, 5);
    chk("gap_hold",  gap_a,   4);

    // 5,6,3,4: backward step
    reset_a();
    push_a(16'd5); push_a(16'd6); push_a(16'd3); push_a(16'd4);
    ticks(10);
    chk("bk_err",   err_a,  1);
    chk("bk_flag",  flag_a, 1);
    chk("bk_fed",   fed_a,  16'd3);
    chk("bk_fee",   fee_a,  16'd7);
    chk("bk_match", match_a, 3);

    // Wrap, large jump, MAX_GAP boundary, duplicate
    reset_a();
    push_a(16'hFFFE); push_a(16'hFFFF); push_a(16'h0000);
    ticks(8);
    chk("wrap_match", match_a, 3);
    chk("wrap_err",   err_a,   0);
    chk("wrap_flag",  flag_a,  0);
    push_a(16'h00C8);
    ticks(4);
    chk("jump_err",  err_a,  1);
    chk("jump_flag", flag_a, 1);
    chk("jump_fed",  fed_a,  16'h00C8);
    chk("jump_fee",  fee_a,  16'h0001);
    push_a(16'h00C9); push_a(16'h010A); push_a(16'h010B); push_a(16'h014D); push_a(16'h014D);
    ticks(10);
    chk("edge_match", match_a, 5);
    chk("edge_gap64", gap_a,   64);
    chk("edge_err",   err_a,   3);
    chk("edge_fed",   fed_a,   16'h00C8);
    chk("edge_fee",   fee_a,   16'h0001);

    // Mid-run reset with a read in flight
    for (int i = 0; i < 5; i++) push_a(16'(500 + i));
    ticks(2);
    reset_a();
    chk("mrst_match", match_a, 0);
    chk("mrst_gap",   gap_a,   0);
    chk("mrst_err",   err_a,   0);
    chk("mrst_flag",  flag_a,  0);
    chk("mrst_fed",   fed_a,   0);
    chk("mrst_fee",   fee_a,   0);
    push_a(16'd100); push_a(16'd101);
    ticks(8);
    chk("resync_match", match_a, 2);
    chk("resync_err",   err_a,   0);
    chk("resync_gap",   gap_a,   0);

    // Enable pause in RUN
    enable_a = 1'b0;
    push_a(16'd102); push_a(16'd103);
    tick();
    chk("pause_rinc", rinc_a_s, 0);
    ticks(3);
    chk("pause_match", match_a, 2);
    enable_a = 1'b1;
    ticks(6);
    chk("resume_match", match_a, 4);
    chk("resume_err",   err_a,   0);

    // Instance B: PACE=2, NUM_WORDS=8
    ticks(1);
    chk("b_rst_match", match_b, 0);
    chk("b_rst_done",  done_b,  0);
    rst_b = 1'b1; en_b = 1'b1; rempty_b = 1'b0;
    rd_b.delete();
    ticks(40);
    chk("pace_reads", rd_b.size(), 8);
    for (int i = 1; i < 8; i++) chk("pace_gap", rd_b[i] - rd_b[i-1], 3);
    chk("done_flag",  done_b,  1);
    chk("done_match", match_b, 8);
    chk("done_err",   err_b,   0);
    chk("done_rinc",  rinc_b_s, 0);

    // Instance B: toggling rempty
    rst_b = 1'b0;
    ticks(2);
    chk("b_rst2_done",  done_b,  0);
    chk("b_rst2_match", match_b, 0);
    rst_b = 1'b1;
    pat = 16'b0100_1101_0010_0110;
    for (int i = 0; i < 80; i++) begin
      rempty_b = pat[i % 16];
      tick();
      chk("rinc_when_empty", rinc_b_s & rempty_b_s, 0);
    end
    chk("tog_done",  done_b,  1);
    chk("tog_match", match_b, 8);
    chk("tog_err",   err_b,   0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_seq_checker.md
Name: fifo_seq_checker

Overview:
Read-side consumer and data checker for the loopback path of async_fifo_top. It sits in the wclk domain on the read port of the return FIFO, whose rclk is tied to wclk. It drains the FIFO under flow control and checks that the returned words form the incrementing sequence produced by the write-side counter generator. It classifies every word as a match, a gap (words dropped while the forward FIFO was full) or a hard error, and reports counts and the first failure.

Parameters:
DW, 16, data width; must match the FIFO data width.
MAX_GAP, 64, largest forward jump accepted as dropped words rather than an error.
NUM_WORDS, 1024, words checked before DONE; 0 means run forever.
PACE, 0, idle wclk cycles inserted between read requests (0 = read every cycle).
CW, 16, width of the statistic counters.

Ports:
wclk  in  1  clock
wrst_n  in  1  synchronous active-low reset, sampled on rising wclk
enable  in  1  start/continue checking; low pauses reading
rempty  in  1  FIFO empty flag, wclk domain
rdata  in  DW  FIFO read data
rvalid  in  1  rdata valid; asserted exactly one cycle after an accepted read
rinc  out  1  read request to the FIFO
match_cnt  out  CW  words equal to the expected value
gap_cnt  out  CW  total dropped words inferred from forward jumps
err_cnt  out  CW  words outside the match/gap window
err_flag  out  1  sticky; set on the first hard error
first_err_data  out  DW  rdata of the first hard error
first_err_exp  out  DW  expected value at the first hard error
done  out  1  sticky; high once NUM_WORDS words have been checked

Behaviour:
- Reset: synchronous only, on wrst_n=0 at a rising wclk edge.
  - All outputs go to 0, the state goes to IDLE, and the expected register and pace counter clear.
  - Reset asserted mid-run discards any in-flight rvalid word. The first rvalid after release is handled in SYNC.
- An accepted read is rinc=1 && rempty=0 in the same cycle. rinc=1 while rempty=1 is legal and ignored by the FIFO; the checker counts it as no read.
- rinc is combinational from state, enable, rempty and the pace counter:
  rinc = (state is SYNC or RUN) && enable && !rempty && pace_cnt==0.
- Pace counter: loads PACE on each accepted read and decrements to 0 otherwise. With PACE=0, back-to-back reads happen every cycle.
- rvalid is processed independently of rinc. A word requested before enable dropped is still checked when its rvalid arrives.
- States:
  - IDLE -> SYNC when enable=1.
  - SYNC: the first rvalid word is adopted without any check. match_cnt increments, expected becomes rdata+1, and the state goes to RUN.
  - RUN: each rvalid word is classified with d = (rdata - expected) mod 2^DW.
    - d==0: match_cnt += 1.
    - 1 <= d <= MAX_GAP: gap_cnt += d.
    - Otherwise (backward step, duplicate, large jump): err_cnt += 1. If err_flag=0, capture first_err_data=rdata and first_err_exp=expected, then set err_flag.
    - In every case expected becomes rdata+1 (resync), and the checked-word count increments.
  - RUN -> DONE when the checked-word count reaches NUM_WORDS (skipped if NUM_WORDS=0). The count includes the SYNC word.
  - DONE: rinc=0 and done=1. Stays here until reset.
- Arithmetic:
  - expected wraps modulo 2^DW, so 0xFFFF followed by 0x0000 is a match for DW=16.
  - Counters saturate at 2^CW-1.
  - gap_cnt addition saturates; it never wraps.
- enable deasserted in RUN: rinc drops the same cycle, state and counters hold, and checking resumes when enable rises.
- The checker never reads while rempty=1. It never depends on rvalid arriving without a prior accepted read; a stray rvalid is still checked.

Test Plan:
- Reset, then enable; the FIFO supplies 0,1,2,…,9 with rempty low -> rinc high every cycle, match_cnt=10, gap_cnt=0, err_cnt=0, err_flag=0.
- Sequence 0,1,2,7,8 -> match_cnt=4, gap_cnt=4, err_cnt=0; the word after 8 is expected to be 9.
- Sequence 5,6,3,4 -> err_cnt=1, err_flag=1, first_err_data=3, first_err_exp=7; the word 4 then counts as a match.
- DW=16, sequence 0xFFFE,0xFFFF,0x0000 -> match_cnt=3, no error; a 200-word jump with MAX_GAP=64 -> err_cnt increments.
- PACE=2 with rempty held low -> rinc is high on 1 cycle in every 3. rempty toggling -> rinc is never high while rempty=1.
- NUM_WORDS=8 -> done rises after the 8th rvalid and rinc stays 0. Pulsing wrst_n low mid-run -> all counters return to 0 and the next word is re-adopted in SYNC.
